// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
//
// Purpose: sequences instruction fetch and the optional load/store for a simple
// multi-cycle core over one shared memory bus. Each instruction is fetched,
// checked for a memory operation, then (if needed) the data access is issued.
// The pipeline is frozen for every state except IDLE.
//
// Optional feature: define MEM_TIMEOUT_EN to add a bus wait-state watchdog.
// After TIMEOUT_CYCLES busy cycles in a wait state it sets the sticky
// timeout_err flag and substitutes a NOP fetch or a zero load. Without the
// macro, wait states last until the bus is no longer busy and timeout_err
// stays 0.
//
// Ports:
//   clk, nRst                  clock, asynchronous active-low reset
//   fetch_req, pc              fetch request and fetch address
//   read_mem, write_mem        decoded load / store for the current instruction
//   load_byte, store_byte      byte-size qualifiers for load / store
//   data_addr, store_data      load/store address and store value
//   bus_busy, bus_rdata        bus handshake and read data
//   bus_addr, bus_wdata,
//   bus_sel, bus_ren, bus_wen  bus request (active in FETCH and DATA only)
//   instruction, load_data     registered fetch and load results
//   freeze                     pipeline stall (low only in IDLE)
//   timeout_err                sticky bus-timeout flag
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic        load_byte,
  input  logic        store_byte,
  input  logic [31:0] data_addr,
  input  logic [31:0] store_data,
  input  logic        bus_busy,
  input  logic [31:0] bus_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [31:0] instruction,
  output logic [31:0] load_data,
  output logic        freeze,
  output logic        timeout_err
);

  // state      | meaning
  // IDLE       | waiting for fetch_req, pipeline running
  // FETCH      | one-cycle instruction read request on the bus
  // FETCH_WAIT | waiting for the bus to finish the instruction read
  // CHECK      | latch memory controls, decide on a data access
  // DATA       | one-cycle load/store request on the bus
  // DATA_WAIT  | waiting for the bus to finish the data access
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH_WAIT,
    CHECK,
    DATA,
    DATA_WAIT
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      r_state;
  state_t      w_next;

  // Access description frozen at CHECK so late control changes cannot alter it
  logic        r_wr;
  logic        r_rd;
  logic        r_byte;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;

  logic        w_tmo;
  logic [7:0]  w_rbyte;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= 32'h0;
      r_sdata <= 32'h0;
    end else if (r_state == CHECK) begin
      // a store wins when both controls are set
      r_wr    <= write_mem;
      r_rd    <= read_mem & ~write_mem;
      r_byte  <= write_mem ? store_byte : load_byte;
      r_addr  <= data_addr;
      r_sdata <= store_data;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_wait_cnt;
  logic        r_timeout_err;
  logic        w_wait;

  assign w_wait = (r_state == FETCH_WAIT) || (r_state == DATA_WAIT);
  // fires on the busy cycle that brings the count to TIMEOUT_CYCLES
  assign w_tmo  = w_wait && bus_busy && (r_wait_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wait_cnt    <= 32'h0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wait_cnt <= (w_wait && bus_busy && !w_tmo) ? r_wait_cnt + 32'h1 : 32'h0;
      if (w_tmo) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_tmo       = 1'b0;
  // constant 0 for any legal TIMEOUT_CYCLES; keeps the parameter referenced
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_rbyte = bus_rdata[7:0];
    case (r_addr[1:0])
      2'd0:    w_rbyte = bus_rdata[7:0];
      2'd1:    w_rbyte = bus_rdata[15:8];
      2'd2:    w_rbyte = bus_rdata[23:16];
      default: w_rbyte = bus_rdata[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      instruction <= 32'h0;
      load_data   <= 32'h0;
    end else begin
      if (r_state == FETCH_WAIT) begin
        if (w_tmo) begin
          instruction <= NOP_INSTR;
        end else if (!bus_busy) begin
          instruction <= bus_rdata;
        end
      end
      if (r_state == DATA_WAIT) begin
        if (w_tmo) begin
          load_data <= 32'h0;
        end else if (!bus_busy && r_rd) begin
          load_data <= r_byte ? {{24{w_rbyte[7]}}, w_rbyte} : bus_rdata;
        end
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    bus_sel   = 4'h0;
    bus_ren   = 1'b0;
    bus_wen   = 1'b0;
    freeze    = 1'b1;
    case (r_state)
      IDLE: begin
        freeze = 1'b0;
        if (fetch_req) begin
          w_next = FETCH;
        end
      end
      FETCH: begin
        bus_addr = pc;
        bus_ren  = 1'b1;
        bus_sel  = 4'hF;
        w_next   = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (w_tmo || !bus_busy) begin
          w_next = CHECK;
        end
      end
      CHECK: begin
        w_next = (read_mem || write_mem) ? DATA : IDLE;
      end
      DATA: begin
        bus_addr = {r_addr[31:2], 2'b00};
        bus_ren  = r_rd;
        bus_wen  = r_wr;
        bus_sel  = (r_wr && r_byte) ? (4'b0001 << r_addr[1:0]) : 4'hF;
        if (r_wr) begin
          bus_wdata = r_byte ? {4{r_sdata[7:0]}} : r_sdata;
        end
        w_next   = DATA_WAIT;
      end
      DATA_WAIT: begin
        if (w_tmo || !bus_busy) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the bus-wait limit in cycles when MEM_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port nRst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_req  in  1  core requests the next instruction.
REQ-005 SHALL have port pc  in  32  fetch address.
REQ-006 SHALL have port read_mem, write_mem, load_byte, store_byte  in  1 each  decoded memory controls for the current instruction.
REQ-007 SHALL have port data_addr  in  32  load/store address from the ALU.
REQ-008 SHALL have port store_data  in  32  rs2 value for stores.
REQ-009 SHALL have port bus_busy  in  1  shared memory bus still servicing the access.
REQ-010 SHALL have port bus_rdata  in  32  bus read data, valid when bus_busy is low in a wait state.
REQ-011 SHALL have ports bus_addr (32), bus_wdata (32), bus_sel (4), bus_ren (1), bus_wen (1)  out  shared memory bus request.
REQ-012 SHALL have ports instruction (32) and load_data (32)  out  registered fetch and load results.
REQ-013 SHALL have ports freeze (1) and timeout_err (1)  out  pipeline stall and sticky bus-timeout flag.

Function
REQ-014 SHALL implement states IDLE, FETCH, FETCH_WAIT, CHECK, DATA, DATA_WAIT.
REQ-015 IDLE: fetch_req=1 -> FETCH; otherwise stay in IDLE.
REQ-016 FETCH: drive bus_addr=pc, bus_ren=1, bus_sel=4'hF for exactly one cycle -> FETCH_WAIT.
REQ-017 FETCH_WAIT: on the first cycle with bus_busy=0, register instruction<=bus_rdata -> CHECK.
REQ-018 CHECK: read_mem|write_mem -> DATA; otherwise -> IDLE. write_mem has priority if both are set.
REQ-019 DATA: drive bus_addr={data_addr[31:2],2'b00} with bus_ren=read_mem or bus_wen=write_mem for exactly one cycle -> DATA_WAIT.
REQ-020 DATA_WAIT: on the first cycle with bus_busy=0, register load_data for reads -> IDLE.
REQ-021 Word access SHALL use bus_sel=4'hF and bus_wdata=store_data.
REQ-022 store_byte SHALL use bus_sel=4'b0001<<data_addr[1:0] and bus_wdata=store_data[7:0] replicated 4 times.
REQ-023 load_byte SHALL set load_data to the byte selected by data_addr[1:0], sign-extended to 32 bits.
REQ-024 Unaligned word addresses SHALL be force-aligned by discarding data_addr[1:0].
REQ-025 freeze SHALL be 0 only in IDLE and 1 in all other states.
REQ-026 Minimum latency SHALL be 4 cycles for a non-memory instruction and 6 cycles for a load or store.
REQ-027 Outputs bus_ren, bus_wen and bus_sel SHALL be 0 outside FETCH and DATA.
REQ-028 bus_busy SHALL be ignored in IDLE, FETCH, CHECK and DATA.
REQ-029 Control-input changes after CHECK SHALL NOT alter the access type of the access in progress (latched at CHECK).

Reset
REQ-030 nRst low SHALL immediately force IDLE and clear instruction, load_data, bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen, freeze and timeout_err to 0, including mid-access.
REQ-031 After nRst is released, the first transition SHALL occur on the next rising edge with fetch_req sampled.

Configuration
REQ-032 Macro MEM_TIMEOUT_EN defined: a wait-state counter SHALL count cycles with bus_busy=1. Reaching TIMEOUT_CYCLES SHALL set timeout_err (sticky until reset), load 32'h0000_0013 (NOP) into instruction or 32'h0 into load_data, and go to CHECK or IDLE respectively.
REQ-033 Macro MEM_TIMEOUT_EN undefined: no counter, timeout_err is tied to 0, and wait states last indefinitely.

Verification
REQ-034 fetch_req=1, pc=32'h100, bus_busy=0, bus_rdata=32'h00A00093, no mem op -> instruction=32'h00A00093, freeze high for 3 cycles then low, bus_ren pulsed once.
REQ-035 LW: data_addr=32'h206, bus_rdata=32'hDEADBEEF on data read -> bus_addr=32'h204, bus_sel=4'hF, load_data=32'hDEADBEEF, 6-cycle cycle count.
REQ-036 LB: data_addr=32'h203, bus_rdata=32'h80112233 -> load_data=32'hFFFFFF80; SB: data_addr=32'h201, store_data=32'h000000AB -> bus_sel=4'b0010, bus_wdata=32'hABABABAB, bus_wen pulsed once.
REQ-037 bus_busy held high 5 cycles in FETCH_WAIT -> no capture until the 6th cycle, freeze held, bus_ren not re-asserted.
REQ-038 nRst asserted in DATA_WAIT -> all outputs 0 at once; after release with fetch_req=1, a clean fetch proceeds from IDLE.
REQ-039 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_busy stuck high in FETCH_WAIT -> after 8 cycles timeout_err=1, instruction=32'h00000013, state CHECK.
